// File: rtl/msp_pkg.sv
// Shared MSP v1 framing constants, FSM state types and the reply descriptor
// used by the responder and its frame transmitter.
package msp_pkg;

    typedef enum logic [2:0] {
        R_IDLE,
        R_M,
        R_DIR,
        R_LEN,
        R_CMD,
        R_PAY,
        R_CHK
    } msp_rx_state_t;

    typedef enum logic [2:0] {
        T_IDLE,
        T_DOLLAR,
        T_M,
        T_DIR,
        T_LEN,
        T_CMD,
        T_DATA,
        T_CHK
    } msp_tx_state_t;

    localparam logic [7:0] MSP_HDR_DOLLAR = 8'h24;
    localparam logic [7:0] MSP_HDR_M      = 8'h4D;
    localparam logic [7:0] MSP_DIR_REQ    = 8'h3C;
    localparam logic [7:0] MSP_DIR_RESP   = 8'h3E;
    localparam logic [7:0] MSP_DIR_ERR    = 8'h21;

    localparam logic [7:0] MSP_API_VERSION     = 8'h01;
    localparam logic [7:0] MSP_FC_VARIANT      = 8'h02;
    localparam logic [7:0] MSP_SET_PASSTHROUGH = 8'hF5;

    // data[0] is the first reply byte on the wire.
    typedef struct packed {
        logic [7:0]        dir;
        logic [7:0]        cmd;
        logic [7:0]        len;
        logic [0:3][7:0]   data;
    } msp_desc_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/msp_responder_if.sv
// PC serial link bundle: receive byte strobe from the UART and the
// ready/valid byte stream back to the UART transmitter.
interface msp_responder_if;
    logic [7:0] pc_rx_data;
    logic       pc_rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport slave (
        input  pc_rx_data,
        input  pc_rx_valid,
        input  tx_ready,
        output tx_data,
        output tx_valid
    );

    modport master (
        output pc_rx_data,
        output pc_rx_valid,
        output tx_ready,
        input  tx_data,
        input  tx_valid
    );
endinterface

// File: rtl/msp_frame_tx.sv
// Serialises one MSP reply frame from a latched descriptor onto a
// ready/valid byte stream; busy stays high until the checksum byte is taken.
module msp_frame_tx
    import msp_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  msp_desc_t  desc,
    input  logic       tx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic       busy
);

    msp_tx_state_t state;
    msp_desc_t     desc_q;
    logic [7:0]    chk;
    logic [2:0]    idx;
    logic          handshake;

    assign busy      = (state != T_IDLE);
    assign handshake = tx_valid & tx_ready;

    // tx_data is only ever loaded on a handshake or on start, so it holds
    // steady while the transmitter stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= T_IDLE;
            desc_q   <= '0;
            chk      <= 8'h00;
            idx      <= 3'd0;
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
        end else begin
            case (state)
                T_IDLE: begin
                    if (start) begin
                        desc_q   <= desc;
                        chk      <= 8'h00;
                        idx      <= 3'd0;
                        tx_data  <= MSP_HDR_DOLLAR;
                        tx_valid <= 1'b1;
                        state    <= T_DOLLAR;
                    end
                end
                T_DOLLAR: begin
                    if (handshake) begin
                        tx_data <= MSP_HDR_M;
                        state   <= T_M;
                    end
                end
                T_M: begin
                    if (handshake) begin
                        tx_data <= desc_q.dir;
                        state   <= T_DIR;
                    end
                end
                T_DIR: begin
                    if (handshake) begin
                        tx_data <= desc_q.len;
                        chk     <= desc_q.len;
                        state   <= T_LEN;
                    end
                end
                T_LEN: begin
                    if (handshake) begin
                        tx_data <= desc_q.cmd;
                        chk     <= chk ^ desc_q.cmd;
                        state   <= T_CMD;
                    end
                end
                T_CMD: begin
                    if (handshake) begin
                        if (desc_q.len != 8'd0) begin
                            tx_data <= desc_q.data[0];
                            chk     <= chk ^ desc_q.data[0];
                            idx     <= 3'd1;
                            state   <= T_DATA;
                        end else begin
                            tx_data <= chk;
                            state   <= T_CHK;
                        end
                    end
                end
                T_DATA: begin
                    if (handshake) begin
                        if ({5'd0, idx} == desc_q.len) begin
                            tx_data <= chk;
                            state   <= T_CHK;
                        end else begin
                            tx_data <= desc_q.data[idx[1:0]];
                            chk     <= chk ^ desc_q.data[idx[1:0]];
                            idx     <= idx + 3'd1;
                        end
                    end
                end
                T_CHK: begin
                    if (handshake) begin
                        tx_valid <= 1'b0;
                        state    <= T_IDLE;
                    end
                end
                default: begin
                    tx_valid <= 1'b0;
                    state    <= T_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/msp_responder.sv
// MSP v1 request parser for the PC link: validates "$M<" requests, answers
// the bridge-discovery commands and raises the passthrough request pulse.
module msp_responder
    import msp_pkg::*;
#(
    parameter int          MAX_PAYLOAD = 16,
    parameter logic [7:0]  MOTOR_COUNT = 8'd4,
    parameter logic [7:0]  API_MAJOR   = 8'd1,
    parameter logic [7:0]  API_MINOR   = 8'd42,
    parameter logic [31:0] FC_VARIANT  = 32'h4254464C
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_ni,
    msp_responder_if.slave  bus,
    output logic            passthrough_req,
    output logic [7:0]      passthrough_ch,
    output logic [7:0]      crc_err_cnt,
    output logic [7:0]      drop_cnt
);

    localparam int         IDXW    = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
    localparam logic [7:0] MAX_LEN = 8'(MAX_PAYLOAD);

    msp_rx_state_t rx_state;
    logic [7:0]    len;
    logic [7:0]    cmd;
    logic [7:0]    chk;
    logic [7:0]    pay_idx;
    logic [7:0]    pay_buf [MAX_PAYLOAD];

    logic          chk_ok;
    logic          oversize;
    logic          tx_busy;
    logic          tx_start;
    msp_desc_t     desc;

    // The reply starts on the same edge that consumes the checksum byte, so
    // tx_valid appears on the following cycle.
    always_comb begin
        chk_ok   = bus.pc_rx_valid && (rx_state == R_CHK) && (bus.pc_rx_data == chk);
        oversize = (len > MAX_LEN);
        tx_start = chk_ok && !oversize && !tx_busy;
    end

    always_comb begin
        desc.dir  = MSP_DIR_ERR;
        desc.cmd  = cmd;
        desc.len  = 8'd0;
        desc.data = '0;
        case (cmd)
            MSP_API_VERSION: begin
                desc.dir  = MSP_DIR_RESP;
                desc.len  = 8'd3;
                desc.data = {8'h00, API_MAJOR, API_MINOR, 8'h00};
            end
            MSP_FC_VARIANT: begin
                desc.dir  = MSP_DIR_RESP;
                desc.len  = 8'd4;
                desc.data = FC_VARIANT;
            end
            MSP_SET_PASSTHROUGH: begin
                desc.dir  = MSP_DIR_RESP;
                desc.len  = 8'd1;
                desc.data = {MOTOR_COUNT, 24'h000000};
            end
            default: ;
        endcase
    end

    // A good-checksum 0xF5 still switches the mux even when its reply is
    // dropped because the transmitter is busy.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            rx_state        <= R_IDLE;
            len             <= 8'd0;
            cmd             <= 8'd0;
            chk             <= 8'd0;
            pay_idx         <= 8'd0;
            pay_buf         <= '{default: 8'h00};
            passthrough_req <= 1'b0;
            passthrough_ch  <= 8'hFF;
            crc_err_cnt     <= 8'd0;
            drop_cnt        <= 8'd0;
        end else begin
            passthrough_req <= 1'b0;
            if (bus.pc_rx_valid) begin
                case (rx_state)
                    R_IDLE: begin
                        if (bus.pc_rx_data == MSP_HDR_DOLLAR) rx_state <= R_M;
                    end
                    R_M: begin
                        rx_state <= (bus.pc_rx_data == MSP_HDR_M) ? R_DIR : R_IDLE;
                    end
                    R_DIR: begin
                        rx_state <= (bus.pc_rx_data == MSP_DIR_REQ) ? R_LEN : R_IDLE;
                    end
                    R_LEN: begin
                        len      <= bus.pc_rx_data;
                        chk      <= bus.pc_rx_data;
                        pay_idx  <= 8'd0;
                        rx_state <= R_CMD;
                    end
                    R_CMD: begin
                        cmd      <= bus.pc_rx_data;
                        chk      <= chk ^ bus.pc_rx_data;
                        rx_state <= (len != 8'd0) ? R_PAY : R_CHK;
                    end
                    R_PAY: begin
                        if (pay_idx < MAX_LEN) pay_buf[pay_idx[IDXW-1:0]] <= bus.pc_rx_data;
                        chk     <= chk ^ bus.pc_rx_data;
                        pay_idx <= pay_idx + 8'd1;
                        if ((pay_idx + 8'd1) == len) rx_state <= R_CHK;
                    end
                    R_CHK: begin
                        if (bus.pc_rx_data == chk) begin
                            if (oversize || tx_busy) drop_cnt <= sat_inc(drop_cnt);
                            if ((cmd == MSP_SET_PASSTHROUGH) && !oversize) begin
                                passthrough_req <= 1'b1;
                                passthrough_ch  <= (len == 8'd0) ? 8'hFF : pay_buf[0];
                            end
                        end else begin
                            crc_err_cnt <= sat_inc(crc_err_cnt);
                        end
                        rx_state <= R_IDLE;
                    end
                    default: rx_state <= R_IDLE;
                endcase
            end
        end
    end

    msp_frame_tx u_frame_tx (
        .clk      (wb_clk_i),
        .rst_n    (wb_rst_ni),
        .start    (tx_start),
        .desc     (desc),
        .tx_ready (bus.tx_ready),
        .tx_data  (bus.tx_data),
        .tx_valid (bus.tx_valid),
        .busy     (tx_busy)
    );

endmodule
